// File: rtl/dy_tone_frame_rx_if.sv
// Bundle between the DY tone detector bank / parser side and the DY frame receiver.
// tone_vld is a strobe with no ready: the receiver accepts tone_flag in every cycle where tone_vld=1.
// dy_rx_en / dy_rx_err are 1-cycle pulses with no backpressure; dy_rx_data/errcode hold between pulses.
interface dy_tone_frame_rx_if;
  logic         cfg_rx_en;
  logic         tone_vld;
  logic [15:0]  tone_flag;
  logic         dy_rx_en;
  logic [127:0] dy_rx_data;
  logic         dy_rx_err;
  logic [1:0]   dy_rx_errcode;
  logic         dy_rx_busy;

  modport master (
    output cfg_rx_en,
    output tone_vld,
    output tone_flag,
    input  dy_rx_en,
    input  dy_rx_data,
    input  dy_rx_err,
    input  dy_rx_errcode,
    input  dy_rx_busy
  );

  modport slave (
    input  cfg_rx_en,
    input  tone_vld,
    input  tone_flag,
    output dy_rx_en,
    output dy_rx_data,
    output dy_rx_err,
    output dy_rx_errcode,
    output dy_rx_busy
  );
endinterface

// File: rtl/dy_tone_frame_rx.sv
// DY frame receiver: debounces tone-presence vectors, locks 9-step timing to the first tone,
// samples each step at its midpoint, checks the doubled preamble and emits the 128-bit instruction.
module dy_tone_frame_rx #(
  parameter int STEP_CYC   = 312500,
  parameter int SAMPLE_OFS = 156250,
  parameter int DEB        = 4,
  parameter int TW         = 20
) (
  input  logic               i_clk_sys,
  input  logic               i_rst,
  dy_tone_frame_rx_if.slave  bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  localparam logic [TW-1:0] TMR_LAST = TW'(STEP_CYC - 1);
  localparam logic [TW-1:0] TMR_SMP  = TW'(SAMPLE_OFS);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [3:0]    DEB_M1   = 4'(DEB - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_last_flag;
  logic [15:0]   r_deb_vec;
  logic [3:0]    r_stable_cnt;
  logic [3:0]    w_stable_nxt;
  logic [TW-1:0] r_step_tmr;
  logic [3:0]    r_step_cnt;
  logic [15:0]   r_pre;
  logic [111:0]  r_shift;
  logic          r_rx_en;
  logic [127:0]  r_rx_data;
  logic          r_rx_err;
  logic [1:0]    r_rx_errcode;
  logic          w_sample;
  logic          w_capture;
  logic          w_err;
  logic [1:0]    w_errcode;
  logic          w_done;

  // Debounce: count consecutive identical strobes; a vector is accepted once it has repeated DEB times.
  always_comb begin
    w_stable_nxt = 4'd0;
    if (bus.tone_flag == r_last_flag) begin
      w_stable_nxt = (r_stable_cnt == 4'hF) ? 4'hF : r_stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_last_flag  <= '0;
      r_stable_cnt <= '0;
      r_deb_vec    <= '0;
    end else if (bus.tone_vld) begin
      r_last_flag  <= bus.tone_flag;
      r_stable_cnt <= w_stable_nxt;
      if (w_stable_nxt >= DEB_M1) begin
        r_deb_vec <= bus.tone_flag;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_errcode   = 2'd0;
    w_done      = 1'b0;
    w_sample    = (r_state == ST_RUN) && (r_step_tmr == TMR_SMP);
    case (r_state)
      ST_IDLE: begin
        if (bus.cfg_rx_en && (r_deb_vec != 16'h0000)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.cfg_rx_en) begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
          w_errcode   = 2'd3;
        end else if (w_sample) begin
          if (r_deb_vec == 16'h0000) begin
            w_state_nxt = ST_GUARD;
            w_err       = 1'b1;
            w_errcode   = 2'd2;
          end else if ((r_step_cnt == 4'd1) && (r_pre != r_deb_vec)) begin
            w_state_nxt = ST_GUARD;
            w_err       = 1'b1;
            w_errcode   = 2'd1;
          end else if (r_step_cnt == 4'd8) begin
            w_state_nxt = ST_GUARD;
            w_done      = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (!bus.cfg_rx_en || (r_deb_vec == 16'h0000)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_capture = w_sample && !w_err;
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Step timer only runs while staying in RUN; entering RUN starts it at 0 (cycle t0).
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_step_tmr <= '0;
      r_step_cnt <= '0;
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_RUN)) begin
      if (r_step_tmr == TMR_LAST) begin
        r_step_tmr <= '0;
        r_step_cnt <= r_step_cnt + 4'd1;
      end else begin
        r_step_tmr <= r_step_tmr + TMR_ONE;
      end
    end else begin
      r_step_tmr <= '0;
      r_step_cnt <= '0;
    end
  end

  // Step 0 holds the first preamble copy; steps 1..7 shift in word7..word1, step 8 supplies word0.
  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_pre   <= '0;
      r_shift <= '0;
    end else if (w_capture) begin
      if (r_step_cnt == 4'd0) begin
        r_pre <= r_deb_vec;
      end else begin
        r_shift <= {r_shift[95:0], r_deb_vec};
      end
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_rx_en      <= 1'b0;
      r_rx_err     <= 1'b0;
      r_rx_errcode <= 2'd0;
      r_rx_data    <= '0;
    end else begin
      r_rx_en  <= w_done;
      r_rx_err <= w_err;
      if (w_err) begin
        r_rx_errcode <= w_errcode;
      end
      if (w_done) begin
        r_rx_data <= {r_shift, r_deb_vec};
      end
    end
  end

  assign bus.dy_rx_en      = r_rx_en;
  assign bus.dy_rx_data    = r_rx_data;
  assign bus.dy_rx_err     = r_rx_err;
  assign bus.dy_rx_errcode = r_rx_errcode;
  assign bus.dy_rx_busy    = (r_state != ST_IDLE);
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_dy_tone_frame_rx.sv
// Directed bench for dy_tone_frame_rx: frames are driven step by step, expected pulses are queued
// and a negedge monitor checks kind, code, data and latency from the frame start.
module tb_dy_tone_frame_rx;
  localparam int STEP = 100;
  localparam int SOFS = 50;
  localparam int W    = 148;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dy_tone_frame_rx_if bus ();

  dy_tone_frame_rx #(
    .STEP_CYC   (STEP),
    .SAMPLE_OFS (SOFS),
    .DEB        (2),
    .TW         (20)
  ) dut (
    .i_clk_sys   (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // {kind(1=frame,2=err), code, latency from t0 (0 = unchecked), data}
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           t0       = 0;
  logic         prev_busy = 1'b0;
  logic [127:0] exp_data;
  logic [15:0]  vec [0:8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] k, input logic [1:0] c,
                                      input logic [15:0] lat, input logic [127:0] d);
    return {k, c, lat, d};
  endfunction

  // Monitor: pops one expected event per output pulse.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.dy_rx_busy && !prev_busy) t0 = cyc;
    prev_busy = bus.dy_rx_busy;
    if (bus.dy_rx_en || bus.dy_rx_err) begin
      check("en_err_exclusive", 128'(bus.dy_rx_en & bus.dy_rx_err), 128'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got en=%0b err=%0b code=%0d expected none", bus.dy_rx_en,
                 bus.dy_rx_err, bus.dy_rx_errcode);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", 128'(bus.dy_rx_en ? 2'd1 : 2'd2), 128'(e[147:146]));
        check("evt_data", bus.dy_rx_data, e[127:0]);
        if (bus.dy_rx_err) check("evt_errcode", 128'(bus.dy_rx_errcode), 128'(e[145:144]));
        if (e[143:128] != 16'd0) check("evt_latency", 128'(cyc - t0), 128'(e[143:128]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.tone_flag = 16'h0000;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic play(input int nsteps, input int glitch_step, input int cut_step);
    for (int s = 0; s < nsteps; s++) begin
      for (int j = 0; j < STEP; j++) begin
        bus.tone_flag = vec[s];
        if (s == glitch_step && j == SOFS) bus.tone_flag = 16'hFFFF;
        if (s == cut_step && j == 10) bus.cfg_rx_en = 1'b0;
        tick();
      end
    end
  endtask

  task automatic load_clean();
    vec[0] = 16'h8001; vec[1] = 16'h8001; vec[2] = 16'h4002;
    vec[3] = 16'h2004; vec[4] = 16'h1008; vec[5] = 16'h0810;
    vec[6] = 16'h0420; vec[7] = 16'h0240; vec[8] = 16'h0180;
  endtask

  localparam logic [127:0] CLEAN = 128'h8001_4002_2004_1008_0810_0420_0240_0180;
  localparam logic [127:0] ALT   = 128'h1234_FFFF_0001_8000_00FF_FF00_5555_AAAA;

  initial begin
    rst = 1'b1;
    bus.cfg_rx_en = 1'b1;
    bus.tone_vld  = 1'b1;
    bus.tone_flag = 16'h0000;
    exp_data = '0;
    for (int i = 0; i < 4; i++) tick();
    check("rst_en", 128'(bus.dy_rx_en), 128'd0);
    check("rst_err", 128'(bus.dy_rx_err), 128'd0);
    check("rst_data", bus.dy_rx_data, 128'd0);
    check("rst_errcode", 128'(bus.dy_rx_errcode), 128'd0);
    check("rst_busy", 128'(bus.dy_rx_busy), 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);
    rst = 1'b0;
    idle(10);

    // 1: clean frame
    load_clean();
    exp_data = CLEAN;
    exp_q.push_back(mk(2'd1, 2'd0, 16'd851, exp_data));
    play(9, -1, -1);
    idle(40);
    check("t1_busy_idle", 128'(bus.dy_rx_busy), 128'd0);
    check("t1_data_held", bus.dy_rx_data, CLEAN);

    // 1b: second frame with a different word pattern
    vec[0] = 16'h1234; vec[1] = 16'h1234; vec[2] = 16'hFFFF;
    vec[3] = 16'h0001; vec[4] = 16'h8000; vec[5] = 16'h00FF;
    vec[6] = 16'hFF00; vec[7] = 16'h5555; vec[8] = 16'hAAAA;
    exp_data = ALT;
    exp_q.push_back(mk(2'd1, 2'd0, 16'd851, exp_data));
    play(9, -1, -1);
    idle(40);
    check("t1b_data_held", bus.dy_rx_data, ALT);

    // 2: preamble mismatch at step 1
    vec[0] = 16'h8001; vec[1] = 16'h8003;
    exp_q.push_back(mk(2'd2, 2'd1, 16'd151, exp_data));
    play(2, -1, -1);
    idle(40);
    check("t2_errcode", 128'(bus.dy_rx_errcode), 128'd1);
    check("t2_data_unchanged", bus.dy_rx_data, ALT);
    check("t2_busy_idle", 128'(bus.dy_rx_busy), 128'd0);

    // 3: one-clock glitch at step 3 midpoint
    load_clean();
    exp_data = CLEAN;
    exp_q.push_back(mk(2'd1, 2'd0, 16'd851, exp_data));
    play(9, 3, -1);
    idle(40);
    check("t3_data", bus.dy_rx_data, CLEAN);

    // 4: dropout from step 5 onward
    load_clean();
    for (int i = 5; i < 9; i++) vec[i] = 16'h0000;
    exp_q.push_back(mk(2'd2, 2'd2, 16'd551, exp_data));
    play(9, -1, -1);
    idle(40);
    check("t4_errcode", 128'(bus.dy_rx_errcode), 128'd2);
    check("t4_busy_idle", 128'(bus.dy_rx_busy), 128'd0);

    // 5: tail tone held after frame end
    load_clean();
    exp_q.push_back(mk(2'd1, 2'd0, 16'd851, exp_data));
    play(9, -1, -1);
    bus.tone_flag = 16'h0180;
    for (int i = 0; i < 500; i++) tick();
    check("t5_busy_tail", 128'(bus.dy_rx_busy), 128'd1);
    check("t5_state_guard", 128'(dbg_state), 128'd2);
    idle(10);
    check("t5_busy_idle", 128'(bus.dy_rx_busy), 128'd0);

    // 6a: receiver disabled during step 4
    exp_q.push_back(mk(2'd2, 2'd3, 16'd0, exp_data));
    play(9, -1, 4);
    idle(40);
    check("t6_errcode", 128'(bus.dy_rx_errcode), 128'd3);
    check("t6_busy_idle", 128'(bus.dy_rx_busy), 128'd0);
    bus.cfg_rx_en = 1'b1;
    idle(10);

    // 6b: reset during step 6
    play(6, -1, -1);
    bus.tone_flag = vec[6];
    for (int i = 0; i < SOFS; i++) tick();
    check("t6_busy_before_rst", 128'(bus.dy_rx_busy), 128'd1);
    rst = 1'b1;
    bus.tone_flag = 16'h0000;
    for (int i = 0; i < 3; i++) tick();
    check("t6_rst_data", bus.dy_rx_data, 128'd0);
    check("t6_rst_errcode", 128'(bus.dy_rx_errcode), 128'd0);
    check("t6_rst_busy", 128'(bus.dy_rx_busy), 128'd0);
    check("t6_rst_en", 128'(bus.dy_rx_en), 128'd0);
    check("t6_rst_err", 128'(bus.dy_rx_err), 128'd0);
    rst = 1'b0;
    idle(1000);
    check("t6_stays_idle", 128'(bus.dy_rx_busy), 128'd0);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
